// File: rtl/mphy_8b10b_pkg.sv
`default_nettype none
// mphy_8b10b_pkg: 8b/10b control-symbol constants, TX sequencer states and disparity helpers.
// Rev 1.0
package mphy_8b10b_pkg;

   localparam logic [8:0] K28_3 = 9'h17C;
   localparam logic [8:0] K28_5 = 9'h1BC;
   localparam logic [8:0] K29_7 = 9'h1FD;

   typedef enum logic [2:0] {
      OFF     = 3'd0,
      PREPARE = 3'd1,
      SYNC    = 3'd2,
      DATA    = 3'd3,
      TAIL    = 3'd4
   } seq_state_t;

   // 1 when the encoded 10b symbol flips running disparity (either sub-block unbalanced, not both).
   function automatic logic disp_toggle(input logic [8:0] sym);
      logic a, b, c, d, e, f, g, h, k;
      logic l22, l13, l31, pd1s6, t6, t4;
      {k, h, g, f, e, d, c, b, a} = sym;
      l22   = (a & b & !c & !d) | (c & d & !a & !b) | ((a ^ b) & (c ^ d));
      l13   = ((a ^ b) & !c & !d) | ((c ^ d) & !a & !b);
      l31   = ((a ^ b) & c & d) | ((c ^ d) & a & b);
      pd1s6 = (e & d & !c & !b & !a) | (!e & !l22 & !l31);
      t6    = pd1s6 | k | (e & !l22 & !l13);
      t4    = (!f & !g) | (f & g & h);
      return t6 ^ t4;
   endfunction

   function automatic logic is_legal_k(input logic [8:0] sym);
      logic k28, kx7;
      k28 = (sym[4:0] == 5'd28);
      kx7 = (sym[7:5] == 3'd7) &&
            ((sym[4:0] == 5'd23) || (sym[4:0] == 5'd27) ||
             (sym[4:0] == 5'd29) || (sym[4:0] == 5'd30));
      return sym[8] && (k28 || kx7);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mphy_tx_symbol_sequencer.sv
`default_nettype none
// mphy_tx_symbol_sequencer: frames M-PHY TX bursts into {K,byte} symbols and tracks running disparity.
// Rev 1.0
module mphy_tx_symbol_sequencer
   import mphy_8b10b_pkg::*;
#(
   parameter int unsigned PREP_LEN     = 4,
   parameter int unsigned SYNC_LEN     = 2,
   parameter int unsigned COMMA_PERIOD = 256,
   parameter logic [8:0]  FILL_SYM     = K28_3,
   parameter logic [8:0]  COMMA_SYM    = K28_5,
   parameter logic [8:0]  END_SYM      = K29_7
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_en,
   input  logic [7:0] in_data,
   input  logic       in_k,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [8:0] enc_datain,
   output logic       enc_dispin,
   output logic       sym_burst,
   output logic       err_illegal_k
);

   localparam int unsigned LEN_MAX = (PREP_LEN > SYNC_LEN) ? PREP_LEN : SYNC_LEN;
   localparam int unsigned LEN_W   = $clog2(LEN_MAX + 1);
   localparam int unsigned PAY_W   = (COMMA_PERIOD == 0) ? 1 : $clog2(COMMA_PERIOD + 1);
   localparam logic [LEN_W-1:0] PREP_LAST = LEN_W'(PREP_LEN - 1);
   localparam logic [LEN_W-1:0] SYNC_LAST = LEN_W'(SYNC_LEN - 1);
   localparam logic [PAY_W-1:0] PAY_FULL  = PAY_W'(COMMA_PERIOD);

   seq_state_t       r_state, w_state_nxt;
   logic [LEN_W-1:0] r_len, w_len_nxt;
   logic [PAY_W-1:0] r_pay, w_pay_nxt;
   logic             r_rd;
   logic [8:0]       w_sym;
   logic             w_burst;
   logic             w_err;
   logic             w_ready;
   logic             w_comma_due;
   logic [8:0]       w_in_sym;

   assign w_in_sym    = {in_k, in_data};
   assign w_comma_due = (COMMA_PERIOD != 0) && (r_pay == PAY_FULL);
   assign in_ready    = w_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= OFF;
         r_len         <= '0;
         r_pay         <= '0;
         r_rd          <= 1'b0;
         enc_datain    <= '0;
         enc_dispin    <= 1'b0;
         sym_burst     <= 1'b0;
         err_illegal_k <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_len         <= w_len_nxt;
         r_pay         <= w_pay_nxt;
         r_rd          <= r_rd ^ disp_toggle(w_sym);
         enc_datain    <= w_sym;
         enc_dispin    <= r_rd;
         sym_burst     <= w_burst;
         err_illegal_k <= w_err;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_len_nxt   = r_len;
      w_pay_nxt   = r_pay;
      w_sym       = FILL_SYM;
      w_burst     = 1'b0;
      w_err       = 1'b0;
      w_ready     = 1'b0;
      case (r_state)
         OFF: begin
            w_len_nxt = '0;
            if (tx_en) w_state_nxt = PREPARE;
         end
         PREPARE: begin
            // An aborted cycle already looks like idle on the line.
            if (!tx_en) begin
               w_state_nxt = OFF;
               w_len_nxt   = '0;
            end else begin
               w_burst = 1'b1;
               if (r_len == PREP_LAST) begin
                  w_state_nxt = SYNC;
                  w_len_nxt   = '0;
               end else begin
                  w_len_nxt = r_len + LEN_W'(1);
               end
            end
         end
         SYNC: begin
            if (!tx_en) begin
               w_state_nxt = OFF;
               w_len_nxt   = '0;
            end else begin
               w_sym   = COMMA_SYM;
               w_burst = 1'b1;
               if (r_len == SYNC_LAST) begin
                  w_state_nxt = DATA;
                  w_len_nxt   = '0;
                  w_pay_nxt   = '0;
               end else begin
                  w_len_nxt = r_len + LEN_W'(1);
               end
            end
         end
         DATA: begin
            w_burst = 1'b1;
            if (w_comma_due) begin
               w_sym     = COMMA_SYM;
               w_pay_nxt = '0;
            end else begin
               w_ready = 1'b1;
               if (in_valid) begin
                  w_pay_nxt = r_pay + PAY_W'(1);
                  if (in_k && !is_legal_k(w_in_sym)) begin
                     w_err = 1'b1;
                  end else begin
                     w_sym = w_in_sym;
                  end
                  if (in_last) w_state_nxt = TAIL;
               end
            end
         end
         TAIL: begin
            w_sym       = END_SYM;
            w_burst     = 1'b1;
            w_state_nxt = OFF;
         end
         default: w_state_nxt = OFF;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mphy_tx_symbol_sequencer.sv
`default_nettype none
// tb_mphy_tx_symbol_sequencer: directed and randomized bursts checked against a symbol-level model.
// Rev 1.0
module tb_mphy_tx_symbol_sequencer;

   localparam int PREP  = 4;
   localparam int SYNCN = 2;
   localparam int CP    = 4;
   localparam logic [8:0] FILL  = 9'h17C;
   localparam logic [8:0] COMMA = 9'h1BC;
   localparam logic [8:0] ENDS  = 9'h1FD;
   // 5b values whose 6b code is unbalanced: D0,1,2,4,8,15,16,23,24,27,29,30,31.
   localparam logic [31:0] UNBAL6 = 32'hE981_8117;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tx_en = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_k = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic [8:0] enc_datain;
   logic       enc_dispin;
   logic       sym_burst;
   logic       err_illegal_k;

   int   n_total = 0;
   int   n_pass  = 0;
   logic rd_m    = 1'b0;
   int   obs_burst, obs_err, obs_comma, obs_nready;
   logic [7:0] pay_d[$];
   logic       pay_k[$];
   logic [7:0] legal_k [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

   mphy_tx_symbol_sequencer #(
      .PREP_LEN     (PREP),
      .SYNC_LEN     (SYNCN),
      .COMMA_PERIOD (CP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .tx_en         (tx_en),
      .in_data       (in_data),
      .in_k          (in_k),
      .in_valid      (in_valid),
      .in_last       (in_last),
      .in_ready      (in_ready),
      .enc_datain    (enc_datain),
      .enc_dispin    (enc_dispin),
      .sym_burst     (sym_burst),
      .err_illegal_k (err_illegal_k)
   );

   always #5 clk = ~clk;

   function automatic logic m_toggle(input logic [8:0] s);
      logic u6, u4;
      u6 = s[8] | UNBAL6[s[4:0]];
      u4 = (s[7:5] == 3'd0) | (s[7:5] == 3'd4) | (s[7:5] == 3'd7);
      return u6 ^ u4;
   endfunction

   function automatic logic m_legal(input logic [8:0] s);
      if (!s[8]) return 1'b1;
      for (int i = 0; i < 12; i++)
         if (legal_k[i] == s[7:0]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic clr_obs();
      obs_burst = 0; obs_err = 0; obs_comma = 0; obs_nready = 0;
   endtask

   task automatic tick(input logic [8:0] esym, input logic eburst, input logic eerr);
      @(posedge clk); #1;
      chk("enc_datain", enc_datain, esym);
      chk("sym_burst", 9'(sym_burst), 9'(eburst));
      chk("err_illegal_k", 9'(err_illegal_k), 9'(eerr));
      chk("enc_dispin", 9'(enc_dispin), 9'(rd_m));
      rd_m = rd_m ^ m_toggle(esym);
      if (sym_burst) obs_burst++;
      if (err_illegal_k) obs_err++;
      if (sym_burst && enc_datain == COMMA) obs_comma++;
   endtask

   task automatic idle(input int n);
      tx_en = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_k = 1'b0;
      repeat (n) begin
         chk("in_ready_idle", 9'(in_ready), 9'd0);
         tick(FILL, 1'b0, 1'b0);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_datain"}, enc_datain, 9'd0);
      chk({tag, "_dispin"}, 9'(enc_dispin), 9'd0);
      chk({tag, "_burst"}, 9'(sym_burst), 9'd0);
      chk({tag, "_err"}, 9'(err_illegal_k), 9'd0);
      chk({tag, "_ready"}, 9'(in_ready), 9'd0);
   endtask

   // One burst over pay_d/pay_k. Payload accepted only when the model says a comma is not due.
   task automatic burst(input int pct, input int gap_after, input int gap_len, input int rst_at);
      int n, idx, nacc, ncomma, gap_left, guard;
      logic due, v, e, done;
      logic [8:0] s;
      n = pay_d.size(); idx = 0; nacc = 0; ncomma = 0;
      gap_left = gap_len; guard = 0; done = 1'b0;
      clr_obs();
      tx_en = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      chk("in_ready_off", 9'(in_ready), 9'd0);
      tick(FILL, 1'b0, 1'b0);
      repeat (PREP) begin
         chk("in_ready_prep", 9'(in_ready), 9'd0);
         tick(FILL, 1'b1, 1'b0);
      end
      repeat (SYNCN) begin
         chk("in_ready_sync", 9'(in_ready), 9'd0);
         tick(COMMA, 1'b1, 1'b0);
      end
      tx_en = 1'b0;
      while (!done) begin
         guard++;
         due = (nacc > 0) && (nacc % CP == 0) && (ncomma < nacc / CP);
         if (nacc == gap_after && gap_left > 0) begin
            v = 1'b0;
            gap_left--;
         end else begin
            v = (guard > 200) || (int'($urandom_range(99)) < pct);
         end
         in_valid = v; in_data = pay_d[idx]; in_k = pay_k[idx]; in_last = (idx == n - 1);
         if (rst_at >= 0 && nacc == rst_at) begin
            reset = 1'b1;
            @(posedge clk); #1;
            chk_reset_values("rst_mid");
            reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; rd_m = 1'b0;
            return;
         end
         #1;
         chk("in_ready_data", 9'(in_ready), 9'(!due));
         if (!in_ready) obs_nready++;
         e = 1'b0;
         if (due) begin
            s = COMMA;
            ncomma++;
         end else if (v) begin
            s = {in_k, in_data};
            e = !m_legal(s);
            if (e) s = FILL;
            nacc++; idx++;
            done = (idx == n);
         end else begin
            s = FILL;
         end
         tick(s, 1'b1, e);
      end
      in_valid = 1'b0; in_last = 1'b0; in_k = 1'b0;
      chk("in_ready_tail", 9'(in_ready), 9'd0);
      tick(ENDS, 1'b1, 1'b0);
   endtask

   task automatic fill_random(input int n, input int kpct);
      pay_d.delete(); pay_k.delete();
      for (int i = 0; i < n; i++) begin
         logic k;
         k = (int'($urandom_range(99)) < kpct);
         pay_k.push_back(k);
         if (k && $urandom_range(1) == 1) pay_d.push_back(legal_k[$urandom_range(11)]);
         else pay_d.push_back(8'($urandom_range(255)));
      end
   endtask

   initial begin
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_values("por");
      reset = 1'b0; rd_m = 1'b0;
      idle(2);

      // Basic three-byte burst.
      pay_d = '{8'h00, 8'hFF, 8'h4A}; pay_k = '{1'b0, 1'b0, 1'b0};
      burst(100, -1, 0, -1);
      chk("t1_burst_len", 9'(obs_burst), 9'd10);
      idle(2);

      // Ten bytes, always valid: commas after the 4th and 8th bytes.
      fill_random(10, 0);
      burst(100, -1, 0, -1);
      chk("t2_ready_low", 9'(obs_nready), 9'd2);
      chk("t2_commas", 9'(obs_comma), 9'd4);
      idle(1);

      // Three-cycle valid gap after two bytes; comma still after the 4th accepted byte.
      fill_random(8, 0);
      burst(100, 2, 3, -1);
      chk("t3_commas", 9'(obs_comma), 9'd3);
      chk("t3_burst_len", 9'(obs_burst), 9'd19);
      idle(1);

      // Illegal K0.0 replaced, legal K28.1 passed through.
      pay_d = '{8'h11, 8'h00, 8'h3C, 8'h55}; pay_k = '{1'b0, 1'b1, 1'b1, 1'b0};
      burst(100, -1, 0, -1);
      chk("t4_err_pulses", 9'(obs_err), 9'd1);
      idle(2);

      // Abort during SYNC: straight back to idle, no END marker.
      clr_obs();
      tx_en = 1'b1;
      tick(FILL, 1'b0, 1'b0);
      repeat (PREP) tick(FILL, 1'b1, 1'b0);
      tick(COMMA, 1'b1, 1'b0);
      tx_en = 1'b0;
      tick(FILL, 1'b0, 1'b0);
      idle(2);
      chk("t5_burst_len", 9'(obs_burst), 9'd5);

      // Randomized bursts with valid gaps and occasional K codes.
      for (int b = 0; b < 8; b++) begin
         int n;
         n = int'($urandom_range(20, 1));
         fill_random(n, 15);
         burst(int'($urandom_range(100, 40)), int'($urandom_range(n - 1, 0)),
               int'($urandom_range(3, 0)), -1);
         idle(int'($urandom_range(3, 0)));
      end

      // Reset while in DATA.
      fill_random(8, 0);
      burst(100, -1, 0, 3);
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
